// File: rtl/counter_ctrl.sv
// Start/stop/pause counter with one-shot or auto-reload terminal action.
// Define COUNTER_CTRL_PRESCALE_EN to build a div-driven prescaler that gates the count tick.
module counter_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  tc,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             tick;
  logic             term;
  logic             advance;

  assign term = (q_q == limit_q);

  // Counting happens only in RUN cycles where neither stop nor pause takes priority.
  assign advance = clear && (state_q == S_RUN) && !stop && !pause;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] pre_q;

  assign tick = (pre_q == div_q);

  always_ff @(posedge clock) begin
    if (!clear) begin
      pre_q <= '0;
      div_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      pre_q <= '0;
      div_q <= div;
    end else if (advance) begin
      pre_q <= tick ? '0 : pre_q + PRESCALE_W'(1);
    end
  end
`else
  logic unused_div;

  assign unused_div = ^div;
  assign tick       = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            q_q     <= '0;
            limit_q <= limit;
            mode_q  <= mode;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (pause) begin
            state_q <= S_HOLD;
          end else if (tick) begin
            if (!term) begin
              q_q <= q_q + WIDTH'(1);
            end else if (mode_q) begin
              q_q <= '0;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_HOLD: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (!pause) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tc    = advance && tick && term;
  assign q     = q_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed-vector bench for counter_ctrl: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares. Prescale vectors apply when COUNTER_CTRL_PRESCALE_EN is defined.
module tb_counter_ctrl;

  localparam int W = 9;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] H = 2'b10;
  localparam logic [1:0] D = 2'b11;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] limit = '0;
  logic [3:0] div   = '0;
  logic [3:0] q;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] state;

  logic [3:0]   div_v;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  counter_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .limit(limit), .div(div), .q(q), .busy(busy), .tc(tc),
    .done(done), .state(state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic step(input logic clr, input logic st, input logic sp, input logic pa,
                      input logic md, input logic [3:0] lim,
                      input logic [1:0] es, input logic [3:0] eq, input logic et);
    @(posedge clock);
    #1;
    clear = clr;
    start = st;
    stop  = sp;
    pause = pa;
    mode  = md;
    limit = lim;
    div   = div_v;
    exp_q.push_back({es, eq, (es == R) || (es == H), es == D, et});
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, q, busy, done, tc};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check #%0d: got state=%b q=%0d busy=%b done=%b tc=%b, expected state=%b q=%0d busy=%b done=%b tc=%b",
                 n_checks, a[8:7], a[6:3], a[2], a[1], a[0], e[8:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    div_v = 4'($urandom_range(1, 15));

    // reset, clear beats start, one-shot limit=3, mid-run input changes and start in DONE ignored
    step(0, 0, 0, 0, 0, 0,  I, 0, 0);
    step(0, 1, 0, 0, 0, 3,  I, 0, 0);
    step(1, 1, 0, 0, 0, 3,  I, 0, 0);
    step(1, 0, 0, 0, 1, 15, R, 0, 0);
    step(1, 1, 0, 0, 1, 15, R, 1, 0);
    step(1, 0, 0, 0, 0, 0,  R, 2, 0);
    step(1, 0, 0, 0, 0, 0,  R, 3, 1);
    step(1, 1, 0, 0, 1, 5,  D, 3, 0);
    step(1, 0, 0, 0, 0, 2,  I, 3, 0);

    // auto-reload limit=2, stop coinciding with terminal count
    step(1, 1, 0, 0, 1, 2,  I, 3, 0);
    step(1, 0, 0, 0, 0, 7,  R, 0, 0);
    step(1, 0, 0, 0, 0, 7,  R, 1, 0);
    step(1, 0, 0, 0, 0, 7,  R, 2, 1);
    step(1, 0, 0, 0, 0, 7,  R, 0, 0);
    step(1, 0, 0, 0, 0, 7,  R, 1, 0);
    step(1, 0, 1, 0, 0, 7,  R, 2, 0);
    step(1, 0, 0, 0, 0, 9,  I, 2, 0);

    // pause at q=5 for three cycles, resume, stop at q=7
    step(1, 1, 0, 0, 0, 9,  I, 2, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 9, R, 4'(i), 0);
    step(1, 0, 0, 1, 0, 9,  R, 5, 0);
    step(1, 0, 0, 1, 0, 9,  H, 5, 0);
    step(1, 0, 0, 1, 0, 9,  H, 5, 0);
    step(1, 0, 0, 0, 0, 9,  H, 5, 0);
    step(1, 0, 0, 0, 0, 9,  R, 5, 0);
    step(1, 0, 0, 0, 0, 9,  R, 6, 0);
    step(1, 0, 1, 0, 0, 9,  R, 7, 0);
    step(1, 0, 0, 0, 0, 9,  I, 7, 0);

    // limit=0 one-shot
    step(1, 1, 0, 0, 0, 0,  I, 7, 0);
    step(1, 0, 0, 0, 0, 0,  R, 0, 1);
    step(1, 0, 0, 0, 0, 0,  D, 0, 0);
    step(1, 0, 0, 0, 0, 0,  I, 0, 0);

    // limit=0 auto-reload, then stop and pause together
    step(1, 1, 0, 0, 1, 0,  I, 0, 0);
    step(1, 0, 0, 0, 0, 0,  R, 0, 1);
    step(1, 0, 0, 0, 0, 0,  R, 0, 1);
    step(1, 0, 1, 1, 0, 0,  R, 0, 0);
    step(1, 0, 0, 0, 0, 0,  I, 0, 0);

    // full range limit=15 one-shot
    step(1, 1, 0, 0, 0, 15, I, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 15, R, 4'(i), i == 15);
    step(1, 0, 0, 0, 0, 15, D, 15, 0);
    step(1, 0, 0, 0, 0, 15, I, 15, 0);

    // clear mid-run at q=4
    step(1, 1, 0, 0, 1, 9,  I, 15, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 9, R, 4'(i), 0);
    step(0, 0, 0, 0, 0, 9,  R, 4, 0);
    step(1, 0, 0, 0, 0, 9,  I, 0, 0);

`ifdef COUNTER_CTRL_PRESCALE_EN
    // div=2, limit=2 one-shot with a pause while q=1
    div_v = 4'd2;
    step(1, 1, 0, 0, 0, 2,  I, 0, 0);
    step(1, 0, 0, 0, 0, 2,  R, 0, 0);
    step(1, 0, 0, 0, 0, 2,  R, 0, 0);
    step(1, 0, 0, 0, 0, 2,  R, 0, 0);
    step(1, 0, 0, 0, 0, 2,  R, 1, 0);
    step(1, 0, 0, 1, 0, 2,  R, 1, 0);
    step(1, 0, 0, 1, 0, 2,  H, 1, 0);
    step(1, 0, 0, 0, 0, 2,  H, 1, 0);
    step(1, 0, 0, 0, 0, 2,  R, 1, 0);
    step(1, 0, 0, 0, 0, 2,  R, 1, 0);
    step(1, 0, 0, 0, 0, 2,  R, 2, 0);
    step(1, 0, 0, 0, 0, 2,  R, 2, 0);
    step(1, 0, 0, 0, 0, 2,  R, 2, 1);
    step(1, 0, 0, 0, 0, 2,  D, 2, 0);
    step(1, 0, 0, 0, 0, 2,  I, 2, 0);
`endif

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
